power_switch_sequencer: RTL and testbench

//  Downstream of the always-on power controller. One instance per switchable domain (inst/gprs/mult/memx/memy).
//  - Turns the controller's level shut-down request (sd = 1 -> power off) into a staged, daisy-chained switch-enable

---
 rtl/pwr_ctrl_pkg.sv | 32 +++
 rtl/psw_delay_counter.sv | 28 ++
 rtl/power_switch_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_power_switch_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pwr_ctrl_pkg.sv
// Shared definitions for the always-on power controller and its switch sequencers:
// state encoding, default delay/timeout constants and the stage-order convention.
package pwr_ctrl_pkg;

    // 3-bit state encoding shared by the controller and every sequencer instance
    localparam logic [2:0] ST_ON     = 3'd0;
    localparam logic [2:0] ST_PD_SEQ = 3'd1;
    localparam logic [2:0] ST_PD_ACK = 3'd2;
    localparam logic [2:0] ST_OFF    = 3'd3;
    localparam logic [2:0] ST_PU_SEQ = 3'd4;
    localparam logic [2:0] ST_PU_ACK = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd6;

    typedef enum logic [2:0] {
        S_ON     = ST_ON,
        S_PD_SEQ = ST_PD_SEQ,
        S_PD_ACK = ST_PD_ACK,
        S_OFF    = ST_OFF,
        S_PU_SEQ = ST_PU_SEQ,
        S_PU_ACK = ST_PU_ACK,
        S_ERR    = ST_ERR
    } psw_state_t;

    // Default sizing / timing
    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_DLY_W      = 8;
    localparam int DEF_TIMEOUT    = 255;

    // Stage order: stage 0 is the trickle switch, higher stages are hammer switches
    localparam int STG_TRICKLE = 0;

endpackage

// File: rtl/psw_delay_counter.sv
// Loadable down-counter with a zero flag; spaces the switch-enable stage steps.
module psw_delay_counter #(
    parameter int DLY_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [DLY_W-1:0] count_reg;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - DLY_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/power_switch_sequencer.sv
// Staged, daisy-chained power-switch sequencer for one switchable domain.
// Converts the controller's level shut-down request into a trickle-first power-up /
// trickle-last power-down enable sequence, then waits for the chain acknowledge.
// Optional feature macro: PSW_TIMEOUT_EN (ack-wait timeout with sticky error and ERR state).
module power_switch_sequencer
    import pwr_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int DLY_W      = DEF_DLY_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sd_req,
    input  logic [DLY_W-1:0]      cfg_trk_dly,
    input  logic [DLY_W-1:0]      cfg_stg_dly,
    input  logic                  sw_ack_in,
    input  logic                  err_clr,
    output logic [NUM_STAGES-1:0] sw_en,
    output logic                  pwr_good,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam logic [NUM_STAGES-1:0] ALL_ON = '1;
    localparam bit SINGLE_STAGE = (NUM_STAGES == 1);

    psw_state_t            state_reg, state_next;
    logic [NUM_STAGES-1:0] sw_en_reg, sw_en_next;
    logic                  pwr_good_reg, pwr_good_next;
    logic                  busy_reg, busy_next;

    logic                  dly_load, dly_dec, dly_zero;
    logic [DLY_W-1:0]      dly_val;

    logic                  to_clr, to_inc, to_expired, err_enter, err_leave;

    logic [NUM_STAGES-1:0] clr_mask, set_mask, pd_step, pu_step;

    // Per-stage masks: highest enabled stage (next to drop) and lowest disabled stage (next to raise)
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
        assign clr_mask[gi] = sw_en_reg[gi] && ((sw_en_reg >> (gi + 1)) == '0);
        assign set_mask[gi] = !sw_en_reg[gi] && ((sw_en_reg | (ALL_ON << gi)) == ALL_ON);
    end

    assign pd_step = sw_en_reg & ~clr_mask;
    assign pu_step = sw_en_reg | set_mask;

    psw_delay_counter #(.DLY_W(DLY_W)) u_dly (
        .clock    (clock),
        .reset    (reset),
        .load     (dly_load),
        .load_val (dly_val),
        .dec      (dly_dec),
        .zero     (dly_zero)
    );

`ifdef PSW_TIMEOUT_EN
    localparam int TO_W = 16;
    logic [TO_W-1:0] to_cnt_reg;
    logic            timeout_err_reg;
    psw_state_t      err_from_reg;

    assign to_expired  = (to_cnt_reg == TO_W'(TIMEOUT - 1));
    assign timeout_err = timeout_err_reg;

    // Ack-wait cycle counter, sticky error flag and the ack state to resume after err_clr
    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
            err_from_reg    <= S_ON;
        end else begin
            if (to_clr) begin
                to_cnt_reg <= '0;
            end else if (to_inc) begin
                to_cnt_reg <= to_cnt_reg + TO_W'(1);
            end
            if (err_enter) begin
                timeout_err_reg <= 1'b1;
                err_from_reg    <= state_reg;
            end else if (err_leave) begin
                timeout_err_reg <= 1'b0;
            end
        end
    end
`else
    logic unused_ok;
    assign to_expired  = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_ok   = err_clr ^ (TIMEOUT == 0) ^ to_clr ^ to_inc ^ err_enter ^ err_leave;
`endif

    // State and registered outputs; reset forces the domain on with no ramp
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= S_ON;
            sw_en_reg    <= ALL_ON;
            pwr_good_reg <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sw_en_reg    <= sw_en_next;
            pwr_good_reg <= pwr_good_next;
            busy_reg     <= busy_next;
        end
    end

    // Next-state, output and counter-control decode
    always_comb begin
        state_next    = state_reg;
        sw_en_next    = sw_en_reg;
        pwr_good_next = pwr_good_reg;
        busy_next     = busy_reg;
        dly_load      = 1'b0;
        dly_dec       = 1'b0;
        dly_val       = cfg_stg_dly;
        to_clr        = 1'b0;
        to_inc        = 1'b0;
        err_enter     = 1'b0;
        err_leave     = 1'b0;
        case (state_reg)
            S_ON: begin
                if (sd_req) begin
                    pwr_good_next = 1'b0;
                    busy_next     = 1'b1;
                    if (SINGLE_STAGE) begin
                        sw_en_next = '0;
                        state_next = S_PD_ACK;
                        to_clr     = 1'b1;
                    end else begin
                        dly_load   = 1'b1;
                        state_next = S_PD_SEQ;
                    end
                end
            end
            S_PD_SEQ: begin
                if (dly_zero) begin
                    sw_en_next = pd_step;
                    dly_load   = 1'b1;
                    if (pd_step == '0) begin
                        state_next = S_PD_ACK;
                        to_clr     = 1'b1;
                    end
                end else begin
                    dly_dec = 1'b1;
                end
            end
            S_PD_ACK: begin
                if (!sw_ack_in) begin
                    state_next = S_OFF;
                    busy_next  = 1'b0;
                end else if (to_expired) begin
                    state_next = S_ERR;
                    err_enter  = 1'b1;
                end else begin
                    to_inc = 1'b1;
                end
            end
            S_OFF: begin
                if (!sd_req) begin
                    sw_en_next[STG_TRICKLE] = 1'b1;
                    busy_next               = 1'b1;
                    if (SINGLE_STAGE) begin
                        state_next = S_PU_ACK;
                        to_clr     = 1'b1;
                    end else begin
                        dly_load   = 1'b1;
                        dly_val    = cfg_trk_dly;
                        state_next = S_PU_SEQ;
                    end
                end
            end
            S_PU_SEQ: begin
                if (dly_zero) begin
                    sw_en_next = pu_step;
                    dly_load   = 1'b1;
                    if (pu_step == ALL_ON) begin
                        state_next = S_PU_ACK;
                        to_clr     = 1'b1;
                    end
                end else begin
                    dly_dec = 1'b1;
                end
            end
            S_PU_ACK: begin
                if (sw_ack_in) begin
                    state_next    = S_ON;
                    pwr_good_next = 1'b1;
                    busy_next     = 1'b0;
                end else if (to_expired) begin
                    state_next = S_ERR;
                    err_enter  = 1'b1;
                end else begin
                    to_inc = 1'b1;
                end
            end
            S_ERR: begin
`ifdef PSW_TIMEOUT_EN
                if (err_clr) begin
                    state_next = err_from_reg;
                    to_clr     = 1'b1;
                    err_leave  = 1'b1;
                end
`else
                state_next    = S_ON;
                sw_en_next    = ALL_ON;
                pwr_good_next = 1'b1;
                busy_next     = 1'b0;
`endif
            end
            default: begin
                state_next    = S_ON;
                sw_en_next    = ALL_ON;
                pwr_good_next = 1'b1;
                busy_next     = 1'b0;
            end
        endcase
    end

    assign sw_en    = sw_en_reg;
    assign pwr_good = pwr_good_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_power_switch_sequencer.sv
// Self-checking bench for power_switch_sequencer: per-cycle vector table plus a
// hand-written long ack wait; expected outputs go through a scoreboard queue.
// Built with or without PSW_TIMEOUT_EN; the timeout scenario runs only when it is defined.
module tb_power_switch_sequencer;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int TMO = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         sd_req;
    logic [W-1:0] cfg_trk_dly;
    logic [W-1:0] cfg_stg_dly;
    logic         sw_ack_in;
    logic         err_clr;
    logic [N-1:0] sw_en;
    logic         pwr_good;
    logic         busy;
    logic         timeout_err;

    power_switch_sequencer #(
        .NUM_STAGES (N),
        .DLY_W      (W),
        .TIMEOUT    (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sd_req      (sd_req),
        .cfg_trk_dly (cfg_trk_dly),
        .cfg_stg_dly (cfg_stg_dly),
        .sw_ack_in   (sw_ack_in),
        .err_clr     (err_clr),
        .sw_en       (sw_en),
        .pwr_good    (pwr_good),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int           id;
        bit           rst;
        bit           sd;
        bit           ack;
        bit           clr;
        logic [W-1:0] trk;
        logic [W-1:0] stg;
        logic [N-1:0] sw;
        bit           pg;
        bit           bsy;
        bit           err;
    } vec_t;

    typedef struct packed {
        logic [N-1:0] sw;
        logic         pg;
        logic         bsy;
        logic         err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input int id, input bit rst, input bit sd, input bit ack,
                                input bit clr, input int trk, input int stg,
                                input logic [N-1:0] sw, input bit pg, input bit bsy,
                                input bit err);
        vec_t v;
        v.id  = id;
        v.rst = rst;
        v.sd  = sd;
        v.ack = ack;
        v.clr = clr;
        v.trk = W'(trk);
        v.stg = W'(stg);
        v.sw  = sw;
        v.pg  = pg;
        v.bsy = bsy;
        v.err = err;
        return v;
    endfunction

    // Append n identical cycles to the vector table
    task automatic add(input int n, input int id, input bit rst, input bit sd, input bit ack,
                       input bit clr, input int trk, input int stg, input logic [N-1:0] sw,
                       input bit pg, input bit bsy, input bit err);
        for (int i = 0; i < n; i++) begin
            vecs.push_back(mk(id, rst, sd, ack, clr, trk, stg, sw, pg, bsy, err));
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge
    task automatic apply(input vec_t v, input int step);
        exp_t want;
        exp_t got;
        reset       = v.rst;
        sd_req      = v.sd;
        sw_ack_in   = v.ack;
        err_clr     = v.clr;
        cfg_trk_dly = v.trk;
        cfg_stg_dly = v.stg;
        sb.push_back({v.sw, v.pg, v.bsy, v.err});
        @(posedge clock);
        #1;
        want = sb.pop_front();
        got  = {sw_en, pwr_good, busy, timeout_err};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL t%0d step%0d sw_en/pg/busy/err got %b/%b/%b/%b want %b/%b/%b/%b",
                     v.id, step, got.sw, got.pg, got.bsy, got.err,
                     want.sw, want.pg, want.bsy, want.err);
        end else begin
            $display("ok   t%0d step%0d sw_en=%b pg=%b busy=%b err=%b",
                     v.id, step, got.sw, got.pg, got.bsy, got.err);
        end
    endtask

    initial begin
        //   n  id rst sd ack clr trk stg  sw       pg bsy err
        // Reset values, then ON holds while sd_req = 0
        add(2,  0, 1,  0, 1,  0,  0,  0,  4'b1111, 1, 0, 0);
        add(1,  0, 0,  0, 1,  0,  0,  0,  4'b1111, 1, 0, 0);
        // Power-down, stage spacing 3 cycles; ack drops one cycle after sw_en == 0
        add(3,  1, 0,  1, 1,  0,  0,  2,  4'b1111, 0, 1, 0);
        add(3,  1, 0,  1, 1,  0,  0,  2,  4'b0111, 0, 1, 0);
        add(3,  1, 0,  1, 1,  0,  0,  2,  4'b0011, 0, 1, 0);
        add(3,  1, 0,  1, 1,  0,  0,  2,  4'b0001, 0, 1, 0);
        add(2,  1, 0,  1, 1,  0,  0,  2,  4'b0000, 0, 1, 0);
        add(2,  1, 0,  1, 0,  0,  0,  2,  4'b0000, 0, 0, 0);
        // Power-up: trickle delay 5 (6 cycles), then stages 2 cycles apart
        add(6,  2, 0,  0, 0,  0,  5,  1,  4'b0001, 0, 1, 0);
        add(2,  2, 0,  0, 0,  0,  5,  1,  4'b0011, 0, 1, 0);
        add(2,  2, 0,  0, 0,  0,  5,  1,  4'b0111, 0, 1, 0);
        add(2,  2, 0,  0, 0,  0,  5,  1,  4'b1111, 0, 1, 0);
        add(2,  2, 0,  0, 1,  0,  5,  1,  4'b1111, 1, 0, 0);
        // sd_req pulses low during PD_SEQ: power-down still completes, then PU starts
        add(1,  3, 0,  1, 1,  0,  0,  0,  4'b1111, 0, 1, 0);
        add(1,  3, 0,  0, 1,  0,  0,  0,  4'b0111, 0, 1, 0);
        add(1,  3, 0,  0, 1,  0,  0,  0,  4'b0011, 0, 1, 0);
        add(1,  3, 0,  0, 1,  0,  0,  0,  4'b0001, 0, 1, 0);
        add(1,  3, 0,  1, 1,  0,  0,  0,  4'b0000, 0, 1, 0);
        add(1,  3, 0,  0, 0,  0,  0,  0,  4'b0000, 0, 0, 0);
        add(1,  3, 0,  0, 0,  0,  0,  0,  4'b0001, 0, 1, 0);
        add(1,  3, 0,  0, 0,  0,  0,  0,  4'b0011, 0, 1, 0);
        add(1,  3, 0,  0, 0,  0,  0,  0,  4'b0111, 0, 1, 0);
        add(1,  3, 0,  0, 0,  0,  0,  0,  4'b1111, 0, 1, 0);
        add(1,  3, 0,  0, 1,  0,  0,  0,  4'b1111, 1, 0, 0);
        // Reset asserted mid-PU_SEQ with sw_en = 0011: forced straight to ON
        add(1,  5, 0,  1, 1,  0,  0,  0,  4'b1111, 0, 1, 0);
        add(1,  5, 0,  1, 0,  0,  0,  0,  4'b0111, 0, 1, 0);
        add(1,  5, 0,  1, 0,  0,  0,  0,  4'b0011, 0, 1, 0);
        add(1,  5, 0,  1, 0,  0,  0,  0,  4'b0001, 0, 1, 0);
        add(1,  5, 0,  1, 0,  0,  0,  0,  4'b0000, 0, 1, 0);
        add(1,  5, 0,  1, 0,  0,  0,  0,  4'b0000, 0, 0, 0);
        add(4,  5, 0,  0, 0,  0,  3,  3,  4'b0001, 0, 1, 0);
        add(1,  5, 0,  0, 0,  0,  3,  3,  4'b0011, 0, 1, 0);
        add(1,  5, 1,  0, 0,  0,  3,  3,  4'b1111, 1, 0, 0);
        add(1,  5, 0,  0, 1,  0,  3,  3,  4'b1111, 1, 0, 0);
`ifdef PSW_TIMEOUT_EN
        // Ack stuck high in PD_ACK: error after 16 cycles, err_clr resumes the wait
        add(1,  4, 0,  1, 1,  0,  0,  0,  4'b1111, 0, 1, 0);
        add(1,  4, 0,  1, 1,  0,  0,  0,  4'b0111, 0, 1, 0);
        add(1,  4, 0,  1, 1,  0,  0,  0,  4'b0011, 0, 1, 0);
        add(1,  4, 0,  1, 1,  0,  0,  0,  4'b0001, 0, 1, 0);
        add(16, 4, 0,  1, 1,  0,  0,  0,  4'b0000, 0, 1, 0);
        add(1,  4, 0,  1, 1,  0,  0,  0,  4'b0000, 0, 1, 1);
        add(1,  4, 0,  1, 0,  0,  0,  0,  4'b0000, 0, 1, 1);
        add(1,  4, 0,  1, 0,  1,  0,  0,  4'b0000, 0, 1, 0);
        add(1,  4, 0,  1, 0,  0,  0,  0,  4'b0000, 0, 0, 0);
        add(1,  4, 0,  1, 0,  1,  0,  0,  4'b0000, 0, 0, 0);
`else
        // Bring the domain down, then up into PU_ACK with no ack
        add(1,  6, 0,  1, 1,  0,  0,  0,  4'b1111, 0, 1, 0);
        add(1,  6, 0,  1, 0,  0,  0,  0,  4'b0111, 0, 1, 0);
        add(1,  6, 0,  1, 0,  0,  0,  0,  4'b0011, 0, 1, 0);
        add(1,  6, 0,  1, 0,  0,  0,  0,  4'b0001, 0, 1, 0);
        add(1,  6, 0,  1, 0,  0,  0,  0,  4'b0000, 0, 1, 0);
        add(1,  6, 0,  1, 0,  0,  0,  0,  4'b0000, 0, 0, 0);
        add(1,  6, 0,  0, 0,  0,  0,  0,  4'b0001, 0, 1, 0);
        add(1,  6, 0,  0, 0,  0,  0,  0,  4'b0011, 0, 1, 0);
        add(1,  6, 0,  0, 0,  0,  0,  0,  4'b0111, 0, 1, 0);
        add(1,  6, 0,  0, 0,  0,  0,  0,  4'b1111, 0, 1, 0);
`endif

        foreach (vecs[k]) begin
            apply(vecs[k], k);
        end

`ifndef PSW_TIMEOUT_EN
        // Without the timeout feature PU_ACK waits indefinitely and never flags an error
        for (int c = 0; c < 1000; c++) begin
            apply(mk(6, 0, 0, 0, 1, 0, 0, 4'b1111, 0, 1, 0), c);
        end
        apply(mk(6, 0, 0, 1, 0, 0, 0, 4'b1111, 1, 0, 0), 1000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
